// File: rtl/des_host_sequencer.sv
// Host-side sequencer for the DES core: accepts one block over valid/ready, runs the level
// start/done handshake with the core, and returns the result (or a watchdog error) over valid/ready.
module des_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_key,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_decrypt,
  output logic        out_error,
  output logic        busy,
  output logic        core_start_encrypt,
  output logic        core_start_decrypt,
  output logic [63:0] core_key,
  output logic [63:0] core_text,
  input  logic        core_done_encrypt,
  input  logic        core_done_decrypt,
  input  logic [63:0] core_output_text
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease, StOut} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            err_q, err_d;
  logic [63:0]     key_q, key_d;
  logic [63:0]     text_q, text_d;
  logic [63:0]     res_q, res_d;

  logic done_sel;
  logic timeout;

  // Only the done that matches the requested direction is meaningful.
  assign done_sel = mode_q ? core_done_decrypt : core_done_encrypt;
  assign timeout  = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    key_d   = key_q;
    text_d  = text_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          key_d   = in_key;
          text_d  = in_data;
          mode_d  = in_decrypt;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (done_sel) begin
          res_d   = core_output_text;
          cnt_d   = '0;
          state_d = StRelease;
        end else if (timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        // done falling confirms the core is back in its idle state
        if (!done_sel) begin
          state_d = StOut;
        end else if (timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      key_q   <= '0;
      text_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      key_q   <= key_d;
      text_q  <= text_d;
      res_q   <= res_d;
    end
  end

  assign in_ready           = (state_q == StIdle);
  assign busy               = (state_q != StIdle);
  assign out_valid          = (state_q == StOut);
  assign core_start_encrypt = (state_q == StIssue) && !mode_q;
  assign core_start_decrypt = (state_q == StIssue) && mode_q;
  assign core_key           = key_q;
  assign core_text          = text_q;
  assign out_data           = res_q;
  assign out_decrypt        = mode_q;
  assign out_error          = err_q;

endmodule

// File: tb/tb_des_host_sequencer.sv
// Directed bench for des_host_sequencer with a behavioural DES core stub (KAT lookup, 20-cycle
// start-to-done latency) that can also be made unresponsive or stuck with done high.
module tb_des_host_sequencer;

  localparam logic [63:0] KatKey = 64'h133457799BBCDFF1;
  localparam logic [63:0] KatPt  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KatCt  = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_decrypt, out_ready;
  logic [63:0] in_key, in_data;
  logic        in_ready, out_valid, out_decrypt, out_error, busy;
  logic [63:0] out_data, core_key, core_text, core_output_text;
  logic        core_start_encrypt, core_start_decrypt, core_done_encrypt, core_done_decrypt;

  int tests = 0;
  int fails = 0;
  int stub_mode = 0;  // 0 normal, 1 never done, 2 done_encrypt stuck high

  always #5 clk = ~clk;

  des_host_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_key(in_key), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_decrypt(out_decrypt), .out_error(out_error), .busy(busy),
    .core_start_encrypt(core_start_encrypt), .core_start_decrypt(core_start_decrypt),
    .core_key(core_key), .core_text(core_text), .core_done_encrypt(core_done_encrypt),
    .core_done_decrypt(core_done_decrypt), .core_output_text(core_output_text)
  );

  // Core stub
  int          cst;
  int          scnt;
  logic        sdir;
  logic [63:0] sres;

  function automatic logic [63:0] des_kat(input logic [63:0] k, input logic [63:0] t,
                                          input logic d);
    if (k == KatKey && t == KatPt && !d) return KatCt;
    if (k == KatKey && t == KatCt && d) return KatPt;
    return t ^ 64'hA5A5_A5A5_A5A5_A5A5;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cst  <= 0;
      scnt <= 0;
      sdir <= 1'b0;
      sres <= 64'hFFFF_0000_FFFF_0000;
    end else begin
      case (cst)
        0: if (stub_mode == 0 && (core_start_encrypt || core_start_decrypt)) begin
          cst  <= 1;
          scnt <= 1;
          sdir <= core_start_decrypt;
        end
        1: if (scnt == 20) begin
          cst  <= 2;
          sres <= des_kat(core_key, core_text, sdir);
        end else begin
          scnt <= scnt + 1;
        end
        default: if (!(core_start_encrypt || core_start_decrypt)) cst <= 0;
      endcase
    end
  end

  assign core_done_encrypt = (cst == 2 && !sdir) || stub_mode == 2;
  assign core_done_decrypt = (cst == 2 && sdir);
  assign core_output_text  = sres;

  // Present a request at a negedge and wait for the accepting edge; wt = idle cycles waited.
  task automatic present_accept(input logic d, input logic [63:0] k, input logic [63:0] t,
                                output int wt);
    @(negedge clk);
    in_valid = 1'b1; in_decrypt = d; in_key = k; in_data = t;
    wt = 0;
    while (!in_ready && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen; record starts seen meanwhile.
  task automatic wait_result(output int lat, output logic saw_enc, output logic saw_dec);
    saw_enc = core_start_encrypt;
    saw_dec = core_start_decrypt;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      saw_enc |= core_start_encrypt;
      saw_dec |= core_start_decrypt;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL consume: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, busy, out_valid, out_error, core_start_encrypt, core_start_decrypt}
        !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 100000", {in_ready, busy, out_valid, out_error,
               core_start_encrypt, core_start_decrypt});
    end
    tests++;
    if (out_data !== 64'h0 || core_key !== 64'h0 || core_text !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: out_data=%h key=%h text=%h want 0", out_data, core_key, core_text);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_kat(input string nm, input logic d, input logic [63:0] t,
                         input logic [63:0] exp);
    int wt, lat;
    logic se, sd;
    present_accept(d, KatKey, t, wt);
    tests++;
    if (core_key !== KatKey || core_text !== t || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_latch: key=%h text=%h busy=%b want %h %h 1", nm, core_key, core_text,
               busy, KatKey, t);
    end
    wait_result(lat, se, sd);
    tests++;
    if (lat !== 24) begin
      fails++;
      $display("FAIL %s_latency: got %0d want 24", nm, lat);
    end
    tests++;
    if (out_data !== exp || out_error !== 1'b0 || out_decrypt !== d) begin
      fails++;
      $display("FAIL %s_result: data=%h err=%b dec=%b want %h 0 %b", nm, out_data, out_error,
               out_decrypt, exp, d);
    end
    tests++;
    if ((d ? se : sd) !== 1'b0 || (d ? sd : se) !== 1'b1) begin
      fails++;
      $display("FAIL %s_starts: enc_seen=%b dec_seen=%b dir=%b", nm, se, sd, d);
    end
  endtask

  task automatic test_encrypt_kat();
    run_kat("enc", 1'b0, KatPt, KatCt);
    consume();
  endtask

  task automatic test_decrypt_kat();
    run_kat("dec", 1'b1, KatCt, KatPt);
    consume();
  endtask

  task automatic test_back_to_back();
    int wt;
    run_kat("bp", 1'b0, KatPt, KatCt);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i >= 5);  // pending request must have no effect outside IDLE
      in_decrypt = 1'b1; in_key = KatKey; in_data = KatCt;
      tests++;
      if (out_valid !== 1'b1 || out_data !== KatCt || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_%0d: v=%b data=%h rdy=%b busy=%b want 1 %h 0 1", i,
                 out_valid, out_data, in_ready, busy, KatCt);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    present_accept(1'b1, KatKey, KatCt, wt);
    tests++;
    if (wt !== 0 || core_text !== KatCt || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: wait=%0d text=%h busy=%b want 0 %h 1", wt, core_text, busy, KatCt);
    end
    begin
      int lat;
      logic se, sd;
      wait_result(lat, se, sd);
      tests++;
      if (lat !== 24 || out_data !== KatPt || out_decrypt !== 1'b1 || out_error !== 1'b0) begin
        fails++;
        $display("FAIL b2b_result: lat=%0d data=%h dec=%b err=%b want 24 %h 1 0", lat, out_data,
                 out_decrypt, out_error, KatPt);
      end
    end
    consume();
  endtask

  task automatic test_watchdog(input int mode, input int exp_lat);
    int wt, lat;
    logic se, sd;
    stub_mode = mode;
    present_accept(1'b0, KatKey, KatPt, wt);
    wait_result(lat, se, sd);
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL wdog%0d_latency: got %0d want %0d", mode, lat, exp_lat);
    end
    tests++;
    if (out_error !== 1'b1 || out_data !== 64'h0 || core_start_encrypt !== 1'b0
        || core_start_decrypt !== 1'b0) begin
      fails++;
      $display("FAIL wdog%0d_abort: err=%b data=%h starts=%b%b want 1 0 00", mode, out_error,
               out_data, core_start_encrypt, core_start_decrypt);
    end
    consume();
    stub_mode = 0;
    run_kat("after_wdog", 1'b0, KatPt, KatCt);
    consume();
  endtask

  task automatic test_reset_midop();
    int wt;
    present_accept(1'b0, KatKey, KatPt, wt);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({in_ready, busy, out_valid, core_start_encrypt, core_start_decrypt} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_midop: rdy/busy/v/se/sd=%b want 10000", {in_ready, busy, out_valid,
               core_start_encrypt, core_start_decrypt});
    end
    @(negedge clk);
    rst = 1'b0;
    run_kat("after_rst", 1'b0, KatPt, KatCt);
    consume();
  endtask

  initial begin
    test_reset();
    test_encrypt_kat();
    test_decrypt_kat();
    test_back_to_back();
    test_watchdog(1, 64);
    test_watchdog(2, 65);
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/des_host_sequencer.md
Name: des_host_sequencer

Overview:
- Host-side initiator for the DES core controller: takes 64-bit blocks, keys and direction over a valid/ready stream.
- Drives the core's start_encrypt/start_decrypt/key/input_text and completes the level-based start/done handshake.
- Returns the result over a valid/ready output stream.
- Adds a watchdog so a non-responding core cannot hang the host.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent waiting in ISSUE or RELEASE before aborting with error; legal range 32..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&in_ready at clk edge
- in_decrypt  input  1  0=encrypt, 1=decrypt
- in_key  input  64  DES key (parity bits ignored)
- in_data  input  64  plaintext/ciphertext block
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid&out_ready at clk edge
- out_data  output  64  result block
- out_decrypt  output  1  direction of the returned result
- out_error  output  1  1 = watchdog abort, out_data forced 0
- busy  output  1  high in any state other than IDLE
- core_start_encrypt  output  1  to core start_encrypt
- core_start_decrypt  output  1  to core start_decrypt
- core_key  output  64  to core key
- core_text  output  64  to core input_text
- core_done_encrypt  input  1  from core done_encrypt
- core_done_decrypt  input  1  from core done_decrypt
- core_output_text  input  64  from core output_text

Behaviour:
- Reset: synchronous, active-high, wins over everything.
  - State=IDLE.
  - All outputs 0 except in_ready=1.
  - Timeout counter=0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, RELEASE, OUT.
- IDLE:
  - in_ready=1.
  - On accept: latch in_key→core_key, in_data→core_text, in_decrypt→mode reg; clear counter; →ISSUE.
  - core_key/core_text stay constant from accept until the next accept.
- ISSUE:
  - core_start_encrypt=~mode, core_start_decrypt=mode. Never both high.
  - Only the done matching mode is watched; the other done is ignored.
  - When matching done=1 at an edge: capture core_output_text→out_data; drop start; clear counter; →RELEASE.
  - Otherwise increment counter.
- RELEASE:
  - Starts low.
  - Wait for matching done=0, which confirms the core has returned to IDLE; then →OUT.
  - Counter increments while waiting.
- OUT:
  - out_valid=1; out_data, out_decrypt and out_error are held stable until consumed.
  - On out_valid&out_ready: →IDLE, out_valid=0.
  - in_ready=0 in OUT, so there is no overlap: one block in flight.
- Watchdog:
  - In ISSUE or RELEASE, if counter==TIMEOUT_CYCLES-1 and the exit condition is false at that edge: starts=0, out_data=0, out_error=1, →OUT.
  - out_error is cleared on the next accept.
  - If the exit condition and the timeout coincide, the exit condition wins (no error).
- Latency with the team's DES core (20 cycles from start seen to done high): out_valid rises 24 cycles after the accept edge.
  - Verification checks the handshake ordering; latency is checked as exactly 24 with the real core.
- Back-to-back: the earliest next accept is the cycle after the out handshake, since IDLE is re-entered with in_ready=1.
- in_valid held without out_ready: no effect outside IDLE; the request stays pending at the source.
- Reset mid-operation: immediate return to IDLE, starts=0, and any captured result is discarded.
  - The core is reset by the same system reset; no extra release wait is required after reset.
- Counter width: ceil(log2(TIMEOUT_CYCLES)); it never wraps, because it saturates at the abort condition.

Test Plan:
- Encrypt KAT: key 133457799BBCDFF1, data 0123456789ABCDEF, in_decrypt=0, out_ready=1 → out_data=85E813540F0AB405, out_error=0, out_decrypt=0, out_valid 24 cycles after accept, core_start_decrypt never high.
- Decrypt KAT: same key, data 85E813540F0AB405, in_decrypt=1 → out_data=0123456789ABCDEF; core_start_encrypt never high.
- Backpressure + back-to-back:
  - Encrypt KAT, hold out_ready=0 for 10 cycles → out_valid/out_data stable, in_ready=0, busy=1.
  - Raise out_ready, then immediately present the decrypt KAT → accepted on the first IDLE cycle; correct second result.
- Watchdog: core stub that never asserts done, TIMEOUT_CYCLES=64 → after 64 ISSUE cycles starts drop, out_valid=1, out_error=1, out_data=0.
  - A following encrypt KAT against the real core passes with out_error=0.
- Stuck-done: stub holds done_encrypt=1 forever → ISSUE exits, RELEASE times out after 64 cycles → out_error=1.
- Reset mid-op: assert rst 10 cycles after accept for one cycle → next cycle state IDLE, in_ready=1, starts=0, out_valid=0; the subsequent encrypt KAT is correct.
